mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage MIPS pipeline; consumes the EX/MEM pipeline-register outputs (control bits, ALU result, rt data, branch PC, zero, load_mode).
- Drives a request/acknowledge data-memory bus for loads and stores, formats byte/half/word data, and resolves branches.
- Stalls upstream while a memory access is outstanding; loads the MEM/WB register for the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 16, ack watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_branch, in_zero  in  1 each  EX/MEM control and flags
- in_load_mode  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned (stores: 00 SW, 01 SH, 1x SB)
- in_dest  in  5  writeback register number
- in_alu_result  in  32  effective address or ALU result
- in_rt  in  32  store data
- in_pc  in  32  branch target from EX
- stall  out  1  upstream must hold EX/MEM contents
- pc_src  out  1  take branch
- branch_target  out  32  target PC
- mem_req, mem_we  out  1 each  bus request, write enable
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data
- mem_ack  in  1  access complete
- wb_valid, wb_RegWrite, wb_MemToReg  out  1 each  MEM/WB control
- wb_read_data, wb_alu_result  out  32 each  MEM/WB data
- wb_dest  out  5  MEM/WB destination
- misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset: state IDLE; every registered output 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, all wb_*, misalign).
- FSM states: IDLE, WAIT.
- stall = (state==WAIT).
- pc_src = in_valid & in_branch & in_zero & (state==IDLE).
- branch_target = in_pc.
- IDLE, in_valid=0: wb_valid<=0 (bubble propagates).
- IDLE, valid non-memory instruction: next edge loads wb_* from in_*, wb_read_data<=0, wb_valid<=1. Latency 1.
- IDLE, valid MemRead or MemWrite, aligned:
  - capture dest/control/address/load_mode into hold registers.
  - mem_req<=1, mem_we<=in_MemWrite, mem_addr<={in_alu_result[31:2],2'b00}.
  - state<=WAIT; wb_valid<=0.
- Misaligned access: word with addr[1:0]!=0, or half with addr[0]!=0.
  - No bus request; misalign<=1 for one cycle.
  - wb_valid<=1 with wb_RegWrite<=0.
- WAIT:
  - mem_req, mem_addr, mem_wdata, mem_be held stable; in_* ignored.
  - On an edge sampling mem_ack=1: mem_req<=0, mem_we<=0; MEM/WB loaded from hold registers and formatted data; wb_valid<=1; state<=IDLE.
  - Earliest ack is the first WAIT cycle, so minimum load-to-wb latency is 2 cycles.
- mem_ack seen in IDLE: ignored.
- Store data and byte enables:
  - SW: wdata=rt, be=1111.
  - SH: wdata={rt[15:0],rt[15:0]}; be=1100 if addr[1] else 0011.
  - SB: wdata=4x rt[7:0]; be=0001<<addr[1:0].
  - Loads drive be=1111.
- Load data:
  - Half: lane rdata[31:16] when addr[1]=1, else rdata[15:0].
  - Byte: lane addr[1:0].
  - Sign- or zero-extend per load_mode.
  - Stores write wb_read_data=0.
- Reset asserted in WAIT aborts the access immediately; mem_req drops asynchronously.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - 5-bit-minimum counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ack: mem_req<=0, state<=IDLE, wb_valid<=1, wb_RegWrite<=0.
  - Output bus_err pulses 1 cycle (port exists only when the macro is defined).
- Undefined: WAIT persists indefinitely until ack; no counter, no bus_err port.

Decomposition:
- Package mem_stage_pkg:
  - load_mode encodings (LM_WORD, LM_HALF, LM_BYTE, LM_BYTEU)
  - state enum (ST_IDLE, ST_WAIT)
  - byte-enable constants
- Sub-module mem_load_align: combinational lane select and sign/zero extension; inputs rdata, addr[1:0], load_mode; output 32-bit data.

Test Plan:
- ALU op: in_valid, RegWrite=1, alu_result=0x0000_0042, dest=5 -> next edge: wb_valid=1, wb_alu_result=0x42, wb_dest=5, stall never high.
- LW at 0x100, ack after 3 WAIT cycles, rdata=0xDEADBEEF -> stall high 3 cycles; wb_read_data=0xDEADBEEF, wb_MemToReg=1.
- LB signed at 0x103, rdata=0x80112233 -> wb_read_data=0xFFFFFF80; LB unsigned same -> 0x00000080; LH at 0x102 -> 0xFFFF8011.
- SB at 0x201, rt=0x000000AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x200; SH at 0x202 -> be=1100.
- LW at 0x102 -> no mem_req, misalign pulse, wb_valid=1, wb_RegWrite=0; BEQ with zero=1, pc=0x400 -> pc_src=1, branch_target=0x400.
- rst_n low during WAIT -> mem_req 0 immediately, all wb_* 0; with MEM_TIMEOUT_EN and no ack -> bus_err after 16 WAIT cycles.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS memory stage: load/store size modes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_stage_pkg;

    localparam logic [1:0] LM_WORD  = 2'b00;
    localparam logic [1:0] LM_HALF  = 2'b01;
    localparam logic [1:0] LM_BYTE  = 2'b10;
    localparam logic [1:0] LM_BYTEU = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_HI  = 4'b1100;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_B0  = 4'b0001;

    // Byte accesses (load or store, modes 1x) can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] lm, input logic [1:0] addr_lo);
        logic bad;
        case (lm)
            LM_WORD: bad = (addr_lo != 2'b00);
            LM_HALF: bad = addr_lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data formatter: picks the half/byte lane addressed by addr[1:0] and
// sign- or zero-extends it according to load_mode.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  load_mode,
    output logic [31:0] data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Lane select and extension
    always_comb begin
        half_s = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        case (load_mode)
            LM_WORD:  data = rdata;
            LM_HALF:  data = {{16{half_s[15]}}, half_s};
            LM_BYTE:  data = {{24{byte_s[7]}}, byte_s};
            LM_BYTEU: data = {24'h00_0000, byte_s};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory stage: req/ack data-memory bus control, store lane formatting,
// load alignment, branch resolution and MEM/WB register.
// Optional macro MEM_TIMEOUT_EN adds an ack watchdog and the bus_err output.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_RegWrite,
    input  logic        in_MemWrite,
    input  logic        in_MemRead,
    input  logic        in_MemToReg,
    input  logic        in_branch,
    input  logic        in_zero,
    input  logic [1:0]  in_load_mode,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_pc,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_dest,
`ifdef MEM_TIMEOUT_EN
    output logic        bus_err,
`endif
    output logic        misalign
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        mem_op_s;
    logic        misal_s;
    logic        tout_hit_s;
    logic        act_pass_s;
    logic        act_misal_s;
    logic        act_issue_s;
    logic        act_done_s;
    logic        act_tout_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;
    logic [31:0] load_data_s;

    logic        hold_regwrite_r;
    logic        hold_memtoreg_r;
    logic        hold_we_r;
    logic [4:0]  hold_dest_r;
    logic [31:0] hold_alu_r;
    logic [1:0]  hold_lm_r;

    assign stall         = (state_r == ST_WAIT);
    assign pc_src        = in_valid & in_branch & in_zero & (state_r == ST_IDLE);
    assign branch_target = in_pc;

    // Store data lane replication and byte enables; loads enable all lanes
    always_comb begin
        wdata_s = 32'h0000_0000;
        be_s    = BE_ALL;
        if (in_MemWrite) begin
            case (in_load_mode)
                LM_WORD: begin
                    wdata_s = in_rt;
                    be_s    = BE_ALL;
                end
                LM_HALF: begin
                    wdata_s = {2{in_rt[15:0]}};
                    be_s    = in_alu_result[1] ? BE_HI : BE_LO;
                end
                default: begin
                    wdata_s = {4{in_rt[7:0]}};
                    be_s    = BE_B0 << in_alu_result[1:0];
                end
            endcase
        end else begin
            wdata_s = 32'h0000_0000;
            be_s    = BE_ALL;
        end
    end

    // Next-state decode and one-hot action selection
    always_comb begin
        state_nxt_s = state_r;
        mem_op_s    = in_MemRead | in_MemWrite;
        misal_s     = is_misaligned(in_load_mode, in_alu_result[1:0]);
        act_pass_s  = 1'b0;
        act_misal_s = 1'b0;
        act_issue_s = 1'b0;
        act_done_s  = 1'b0;
        act_tout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!in_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if (!mem_op_s) begin
                    act_pass_s = 1'b1;
                end else if (misal_s) begin
                    act_misal_s = 1'b1;
                end else begin
                    act_issue_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    act_done_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (tout_hit_s) begin
                    act_tout_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold registers: EX/MEM may change while the access is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_regwrite_r <= 1'b0;
            hold_memtoreg_r <= 1'b0;
            hold_we_r       <= 1'b0;
            hold_dest_r     <= 5'd0;
            hold_alu_r      <= 32'h0000_0000;
            hold_lm_r       <= 2'b00;
        end else if (act_issue_s) begin
            hold_regwrite_r <= in_RegWrite;
            hold_memtoreg_r <= in_MemToReg;
            hold_we_r       <= in_MemWrite;
            hold_dest_r     <= in_dest;
            hold_alu_r      <= in_alu_result;
            hold_lm_r       <= in_load_mode;
        end
    end

    // Bus request registers; address, data and enables stay frozen through WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_be    <= 4'b0000;
        end else if (act_issue_s) begin
            mem_req   <= 1'b1;
            mem_we    <= in_MemWrite;
            mem_addr  <= {in_alu_result[31:2], 2'b00};
            mem_wdata <= wdata_s;
            mem_be    <= be_s;
        end else if (act_done_s || act_tout_s) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    mem_load_align u_align (
        .rdata     (mem_rdata),
        .addr      (hold_alu_r[1:0]),
        .load_mode (hold_lm_r),
        .data      (load_data_s)
    );

    // MEM/WB register; failed accesses complete with the register write suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
            wb_read_data  <= 32'h0000_0000;
            wb_alu_result <= 32'h0000_0000;
            wb_dest       <= 5'd0;
        end else begin
            wb_valid <= act_pass_s | act_misal_s | act_done_s | act_tout_s;
            if (act_pass_s || act_misal_s) begin
                wb_RegWrite   <= in_RegWrite & act_pass_s;
                wb_MemToReg   <= in_MemToReg;
                wb_read_data  <= 32'h0000_0000;
                wb_alu_result <= in_alu_result;
                wb_dest       <= in_dest;
            end else if (act_done_s) begin
                wb_RegWrite   <= hold_regwrite_r;
                wb_MemToReg   <= hold_memtoreg_r;
                wb_read_data  <= hold_we_r ? 32'h0000_0000 : load_data_s;
                wb_alu_result <= hold_alu_r;
                wb_dest       <= hold_dest_r;
            end else if (act_tout_s) begin
                wb_RegWrite   <= 1'b0;
                wb_MemToReg   <= hold_memtoreg_r;
                wb_read_data  <= 32'h0000_0000;
                wb_alu_result <= hold_alu_r;
                wb_dest       <= hold_dest_r;
            end
        end
    end

    // Misalignment pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= act_misal_s;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;

    logic [CNT_W-1:0] tout_cnt_r;

    // The last WAIT cycle before the limit is the one that gives up
    assign tout_hit_s = (tout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Ack watchdog counter, restarted on every issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tout_cnt_r <= '0;
        end else if (act_issue_s) begin
            tout_cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            tout_cnt_r <= tout_cnt_r + CNT_W'(1);
        end
    end

    // Bus error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= act_tout_s;
        end
    end
`else
    assign tout_hit_s = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// instruction streams checked against an arithmetic reference model.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_branch, in_zero;
    logic [1:0]  in_load_mode;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result, in_rt, in_pc;
    logic        stall, pc_src;
    logic [31:0] branch_target;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_RegWrite, wb_MemToReg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_dest;
    logic        misalign;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_RegWrite(in_RegWrite),
        .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_MemToReg(in_MemToReg),
        .in_branch(in_branch), .in_zero(in_zero), .in_load_mode(in_load_mode),
        .in_dest(in_dest), .in_alu_result(in_alu_result), .in_rt(in_rt), .in_pc(in_pc),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_dest(wb_dest),
`ifdef MEM_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, written from the access-size rules with plain arithmetic
    function automatic logic exp_misal(input logic [1:0] lm, input logic [31:0] a);
        if (lm == 2'd0) return (a % 32'd4) != 32'd0;
        if (lm == 2'd1) return (a % 32'd2) != 32'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic we, input logic [1:0] lm, input logic [31:0] a);
        logic [31:0] one_hot;
        if (!we || lm == 2'd0) return 4'hF;
        if (lm == 2'd1) return ((a % 32'd4) >= 32'd2) ? 4'hC : 4'h3;
        one_hot = 32'd1 << (a % 32'd4);
        return one_hot[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] lm, input logic [31:0] rt);
        if (lm == 2'd0) return rt;
        if (lm == 2'd1) return (rt & 32'h0000_FFFF) * 32'h0001_0001;
        return (rt & 32'h0000_00FF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] lm, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (lm == 2'd0) return rd;
        if (lm == 2'd1) begin
            v = (rd >> (32'd16 * ((a / 32'd2) % 32'd2))) & 32'h0000_FFFF;
            return (v >= 32'h0000_8000) ? (v | 32'hFFFF_0000) : v;
        end
        v = (rd >> (32'd8 * (a % 32'd4))) & 32'h0000_00FF;
        if (lm == 2'd2 && v >= 32'h0000_0080) return v | 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic drive_bubble();
        in_valid = 1'b0; in_RegWrite = 1'b0; in_MemWrite = 1'b0; in_MemRead = 1'b0;
        in_MemToReg = 1'b0; in_branch = 1'b0; in_zero = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        drive_bubble();
        rst_n = 1'b0; in_load_mode = 2'd0; in_dest = 5'd0; in_alu_result = 32'd0;
        in_rt = 32'd0; in_pc = 32'd0; mem_rdata = 32'd0;
        #2;
        n_checks++;
        if ({mem_req, mem_we, mem_be, misalign, stall} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {mem_req, mem_we, mem_be, misalign, stall});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata});
        end
        n_checks++;
        if ({wb_valid, wb_RegWrite, wb_MemToReg, wb_read_data, wb_alu_result, wb_dest} !== 72'd0) begin
            n_fail++; $display("FAIL reset_wb: got %h expected 0", {wb_valid, wb_RegWrite, wb_MemToReg, wb_read_data, wb_alu_result, wb_dest});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_alu(input logic rw, input logic [4:0] dest, input logic [31:0] res, input logic m2r);
        @(negedge clk);
        drive_bubble();
        in_valid = 1'b1; in_RegWrite = rw; in_MemToReg = m2r; in_dest = dest; in_alu_result = res;
        in_load_mode = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        n_checks++;
        if ({wb_valid, wb_RegWrite, wb_MemToReg, wb_dest, stall} !== {1'b1, rw, m2r, dest, 1'b0}) begin
            n_fail++; $display("FAIL alu_ctrl: got %b expected %b", {wb_valid, wb_RegWrite, wb_MemToReg, wb_dest, stall}, {1'b1, rw, m2r, dest, 1'b0});
        end
        n_checks++;
        if ({wb_alu_result, wb_read_data, mem_req} !== {res, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL alu_data: got %h/%h expected %h/0", wb_alu_result, wb_read_data, res);
        end
    endtask

    task automatic do_bubble();
        @(negedge clk);
        drive_bubble();
        in_dest = 5'($urandom); in_alu_result = $urandom;
        @(posedge clk); #1;
        n_checks++;
        if ({wb_valid, mem_req, misalign, stall} !== 4'b0000) begin
            n_fail++; $display("FAIL bubble: got %b expected 0000", {wb_valid, mem_req, misalign, stall});
        end
    endtask

    // One load/store through the bus; garbage is put on in_* while waiting
    task automatic do_mem(input logic we, input logic [1:0] lm, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input logic [4:0] dest, input logic rw, input int ack_wait);
        int stall_seen = 0;
        @(negedge clk);
        drive_bubble();
        in_valid = 1'b1; in_MemRead = ~we; in_MemWrite = we; in_MemToReg = ~we; in_RegWrite = rw;
        in_load_mode = lm; in_dest = dest; in_alu_result = addr; in_rt = rt;
        @(posedge clk); #1;
        if (exp_misal(lm, addr)) begin
            n_checks++;
            if ({misalign, mem_req, wb_valid, wb_RegWrite, stall} !== 5'b10100) begin
                n_fail++; $display("FAIL misalign_pulse @%h: got %b expected 10100", addr, {misalign, mem_req, wb_valid, wb_RegWrite, stall});
            end
            @(negedge clk); drive_bubble();
            @(posedge clk); #1;
            n_checks++;
            if (misalign !== 1'b0) begin
                n_fail++; $display("FAIL misalign_width: got %b expected 0", misalign);
            end
            return;
        end
        n_checks++;
        if ({mem_req, mem_we, mem_be, stall, wb_valid} !== {1'b1, we, exp_be(we, lm, addr), 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL issue_ctrl @%h: got %b expected %b", addr, {mem_req, mem_we, mem_be, stall, wb_valid}, {1'b1, we, exp_be(we, lm, addr), 1'b1, 1'b0});
        end
        n_checks++;
        if (mem_addr !== (addr & 32'hFFFF_FFFC) || (we && mem_wdata !== exp_wdata(lm, rt))) begin
            n_fail++; $display("FAIL issue_bus: got %h/%h expected %h/%h", mem_addr, mem_wdata, addr & 32'hFFFF_FFFC, exp_wdata(lm, rt));
        end
        for (int k = 1; k <= ack_wait; k++) begin
            @(negedge clk);
            in_dest = 5'($urandom); in_alu_result = $urandom; in_rt = $urandom;
            in_load_mode = 2'($urandom_range(0, 3)); in_branch = 1'b1; in_zero = 1'b1;
            mem_ack = (k == ack_wait);
            mem_rdata = (k == ack_wait) ? rdata : $urandom;
            #1;
            if (stall === 1'b1) stall_seen++;
            n_checks++;
            if ({pc_src, mem_req} !== 2'b01 || mem_addr !== (addr & 32'hFFFF_FFFC)) begin
                n_fail++; $display("FAIL wait_hold: got pc_src=%b req=%b addr=%h expected 0/1/%h", pc_src, mem_req, mem_addr, addr & 32'hFFFF_FFFC);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (stall_seen != ack_wait) begin
            n_fail++; $display("FAIL stall_cycles: got %0d expected %0d", stall_seen, ack_wait);
        end
        n_checks++;
        if ({stall, mem_req, mem_we, wb_valid, wb_RegWrite, wb_MemToReg, wb_dest} !== {3'b000, 1'b1, rw, ~we, dest}) begin
            n_fail++; $display("FAIL done_ctrl @%h: got %b expected %b", addr, {stall, mem_req, mem_we, wb_valid, wb_RegWrite, wb_MemToReg, wb_dest}, {3'b000, 1'b1, rw, ~we, dest});
        end
        n_checks++;
        if (wb_read_data !== (we ? 32'd0 : exp_load(lm, addr, rdata)) || wb_alu_result !== addr) begin
            n_fail++; $display("FAIL done_data @%h lm=%0d: got %h/%h expected %h/%h", addr, lm, wb_read_data, wb_alu_result, we ? 32'd0 : exp_load(lm, addr, rdata), addr);
        end
        @(negedge clk); drive_bubble();
    endtask

    task automatic test_alu();
        do_alu(1'b1, 5'd5, 32'h0000_0042, 1'b0);
        do_bubble();
        do_alu(1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_loads();
        do_mem(1'b0, 2'd0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 5'd7, 1'b1, 3);
        do_mem(1'b0, 2'd2, 32'h0000_0103, 32'd0, 32'h8011_2233, 5'd8, 1'b1, 1);
        do_mem(1'b0, 2'd3, 32'h0000_0103, 32'd0, 32'h8011_2233, 5'd9, 1'b1, 2);
        do_mem(1'b0, 2'd1, 32'h0000_0102, 32'd0, 32'h8011_2233, 5'd10, 1'b1, 1);
    endtask

    task automatic test_stores();
        do_mem(1'b1, 2'd2, 32'h0000_0201, 32'h0000_00AB, 32'd0, 5'd0, 1'b0, 1);
        do_mem(1'b1, 2'd1, 32'h0000_0202, 32'h1234_5678, 32'd0, 5'd0, 1'b0, 2);
        do_mem(1'b1, 2'd0, 32'h0000_0204, 32'hCAFE_F00D, 32'd0, 5'd0, 1'b0, 1);
    endtask

    task automatic test_misalign();
        do_mem(1'b0, 2'd0, 32'h0000_0102, 32'd0, 32'd0, 5'd3, 1'b1, 1);
        do_mem(1'b1, 2'd1, 32'h0000_0301, 32'h5555_AAAA, 32'd0, 5'd0, 1'b0, 1);
    endtask

    task automatic test_branch();
        @(negedge clk);
        drive_bubble();
        in_valid = 1'b1; in_branch = 1'b1; in_zero = 1'b1; in_pc = 32'h0000_0400;
        #1;
        n_checks++;
        if ({pc_src, branch_target} !== {1'b1, 32'h0000_0400}) begin
            n_fail++; $display("FAIL branch_taken: got %b/%h expected 1/00000400", pc_src, branch_target);
        end
        in_zero = 1'b0;
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin
            n_fail++; $display("FAIL branch_not_taken: got %b expected 0", pc_src);
        end
        @(posedge clk); #1;
        @(negedge clk); drive_bubble();
    endtask

    task automatic test_ack_idle();
        @(negedge clk);
        drive_bubble();
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({stall, mem_req, wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL ack_idle: got %b expected 000", {stall, mem_req, wb_valid});
        end
        @(negedge clk); drive_bubble();
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        drive_bubble();
        in_valid = 1'b1; in_MemRead = 1'b1; in_MemToReg = 1'b1; in_RegWrite = 1'b1;
        in_load_mode = 2'd0; in_alu_result = 32'h0000_0300; in_dest = 5'd12;
        @(posedge clk); #1;
        n_checks++;
        if ({mem_req, stall} !== 2'b11) begin
            n_fail++; $display("FAIL rst_wait_setup: got %b expected 11", {mem_req, stall});
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, stall, wb_valid, wb_RegWrite, wb_MemToReg, wb_read_data, wb_alu_result, wb_dest} !== 74'd0) begin
            n_fail++; $display("FAIL rst_in_wait: got req=%b stall=%b wb_alu=%h wb_dest=%0d expected all 0", mem_req, stall, wb_alu_result, wb_dest);
        end
        @(negedge clk); drive_bubble();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] a, rt, rd;
        logic [1:0]  lm;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; rt = $urandom; rd = $urandom; lm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: do_bubble();
                1: do_alu(1'($urandom), 5'($urandom), $urandom, 1'($urandom));
                2: do_mem(1'b0, lm, a, rt, rd, 5'($urandom), 1'b1, $urandom_range(1, 4));
                default: do_mem(1'b1, lm, a, rt, rd, 5'($urandom), 1'b0, $urandom_range(1, 4));
            endcase
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic early = 1'b0;
        @(negedge clk);
        drive_bubble();
        in_valid = 1'b1; in_MemRead = 1'b1; in_RegWrite = 1'b1; in_load_mode = 2'd0;
        in_alu_result = 32'h0000_0500;
        @(posedge clk); #1;
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            if (stall !== 1'b1 || bus_err !== 1'b0) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++; $display("FAIL timeout_early: got early exit expected 15 WAIT cycles");
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus_err, stall, mem_req, wb_valid, wb_RegWrite} !== 5'b10010) begin
            n_fail++; $display("FAIL timeout: got %b expected 10010", {bus_err, stall, mem_req, wb_valid, wb_RegWrite});
        end
        @(negedge clk); drive_bubble();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misalign();
        test_branch();
        test_ack_idle();
        test_reset_in_wait();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
